muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit. It replaces the separate fixed-width DIV and MULT blocks that feed HI/LO in the multicycle MIPS datapath.
- One shared shift-add / restoring-divide engine handles MULT, MULTU, DIV and DIVU.
- Results are held internally and presented as hi/lo. The control unit stalls on busy and sequences on done.
- Divide-by-zero is flagged for the exception logic, alongside Overflow.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH bits split across hi/lo; legal range 4..64.
- SIGNED_EN, 1, when 0 the signed ops (MULT, DIV) execute as their unsigned forms.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  in  WIDTH  multiplicand / dividend (register A).
- b  in  WIDTH  multiplier / divisor (register B).
- abort  in  1  synchronous cancel of an operation in progress.
- busy  out  1  high while in CALC or FIX.
- done  out  1  single-cycle completion pulse.
- div_zero  out  1  valid with done; divisor was zero.
- hi  out  WIDTH  MULT: upper product; DIV: remainder.
- lo  out  WIDTH  MULT: lower product; DIV: quotient.

Behaviour:
- Reset: when reset is 0, asynchronously force state=IDLE and counter=0. Force busy, done, div_zero, hi, lo and all internal datapath registers to 0.
- States are IDLE, CALC and FIX; the counter is ceil(log2(WIDTH+1)) bits.
- IDLE, start=1, divide op with b==0:
  - Stay in IDLE.
  - Next cycle: done=1 and div_zero=1.
  - hi/lo unchanged.
- IDLE, start=1, any other case (call this edge E0):
  - Latch op and operand signs.
  - Load the magnitudes |a| and |b|. Signed ops use two's-complement negation when the sign bit is 1; unsigned ops and SIGNED_EN=0 use raw values.
  - Clear the accumulator and remainder, set counter=0, go to CALC.
- CALC, one iteration per cycle, counter incremented each cycle:
  - Multiply: add the multiplicand into the upper half of a 2*WIDTH accumulator if the multiplier LSB is 1, then shift right 1.
  - Divide: restoring. Shift {rem, dividend} left 1, trial-subtract the divisor, keep the result if it is non-negative and set quotient bit = 1.
  - After WIDTH iterations (edge E_WIDTH) go to FIX.
- FIX, one cycle (edge E_WIDTH+1):
  - Apply sign correction and write hi/lo.
  - Pulse done=1 with div_zero=0 for one cycle, drop busy, return to IDLE.
  - Total latency is WIDTH+1 cycles from the start edge to the cycle done is high (33 for WIDTH=32).
- Sign rules:
  - Signed product is negated when the operand signs differ.
  - Signed quotient truncates toward zero and is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - MIN / -1 yields quotient=MIN, remainder=0, with no flag.
- Handshake rules:
  - start is ignored while busy.
  - start is accepted in the same cycle done is high, because the state is IDLE.
  - hi/lo change only on a FIX completion; otherwise they hold indefinitely.
  - div_zero and done deassert the following cycle unless a new zero-divide is accepted.
- abort=1 in CALC or FIX: return to IDLE next edge with busy=0, no done, and hi/lo unchanged. abort in IDLE has no effect. abort and start in the same IDLE cycle: start wins.
- Reset asserted mid-operation: the operation is discarded and all outputs read 0. After release, the unit is IDLE and accepts start on the first edge.

Test Plan:
- WIDTH=32, MULT a=FFFFFFFD, b=00000005 -> done exactly 33 cycles after the start edge; hi=FFFFFFFF, lo=FFFFFFF1; busy high for 33 cycles.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then MULT with the same operands -> hi=00000000, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_zero=0.
- After a result of hi=1, lo=3: DIVU a=5, b=0 -> done and div_zero high the next cycle, busy never high, hi=1, lo=3 retained. Also: start pulsed at cycle 10 of a MULT is ignored and the original result is unchanged.
- Start MULT, pulse abort at cycle 10 -> busy low next cycle, no done, hi/lo unchanged. Repeat with reset=0 at cycle 10 -> hi=lo=0, busy=done=0 immediately (async). After release, DIVU 100/7 -> lo=14, hi=2.
- WIDTH=8, SIGNED_EN=0: DIV a=F9, b=02 -> unsigned result lo=7C, hi=01, done 9 cycles after start. Back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the HI/LO path: one shift-add / restoring-divide
// iteration per cycle in CALC, sign correction in FIX, result held on hi/lo.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;   // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd;  // multiplicand or divisor magnitude
    logic               op_div, neg_res, neg_rem;

    logic             req_div, req_signed, sign_a, sign_b, req_zero;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        req_div    = op[1];
        req_signed = SIGNED_EN && !op[0];
        sign_a     = req_signed && a[WIDTH-1];
        sign_b     = req_signed && b[WIDTH-1];
        mag_a      = sign_a ? -a : a;
        mag_b      = sign_b ? -b : b;
        req_zero   = req_div && (b == '0);
    end

    logic accept, zero_hit, finish;

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        zero_hit   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_zero) begin
                        zero_hit = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (abort)                   state_next = IDLE;
                else if (count == LAST_ITER) state_next = FIX;
            end
            FIX: begin
                state_next = IDLE;
                finish     = !abort;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= finish | zero_hit;
            div_zero <= zero_hit;
            if (accept)             count <= '0;
            else if (state == CALC) count <= count + CW'(1);
        end
    end

    assign busy = (state != IDLE);

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_fits  = div_trial >= {1'b0, opnd};
        div_rem   = WIDTH'(div_trial - {1'b0, opnd});
        if (op_div) begin
            // a partial remainder that fails the trial is below 2^(WIDTH-1), so the shift loses nothing
            if (div_fits) acc_step = {div_rem, acc[WIDTH-2:0], 1'b1};
            else          acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // NOTE: the datapath is reset too, so a reset mid-operation leaves nothing stale on hi/lo.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            opnd    <= '0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (accept) begin
                op_div  <= req_div;
                neg_res <= sign_a ^ sign_b;
                neg_rem <= sign_a;
                opnd    <= req_div ? mag_b : mag_a;
                acc     <= {{WIDTH{1'b0}}, (req_div ? mag_a : mag_b)};
            end else if (state == CALC) begin
                acc <= acc_step;
            end
            if (finish) begin
                hi <= op_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo <= op_div ? quo_fix : prod_fix[WIDTH-1:0];
            end
        end
    end
endmodule
